// File: rtl/cache_pkg.sv
// Shared types and helpers for the write-back set-associative cache.
// The line record lives in assoc_cache_wb because its tag and data widths come from that module's parameters.
package cache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_WB,
        ST_FILL,
        ST_RESP
    } state_t;

    // Smallest r with (1 << r) >= n; evaluated at elaboration for derived widths.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cache_lru_set.sv
// True-LRU age vector for one cache set: age 0 is most recent, WAYS-1 is the victim.
// Ages stay a permutation of 0..WAYS-1 because only ways younger than the accessed one age.
module cache_lru_set
    import cache_pkg::*;
#(
    parameter int WAYS = 4,
    localparam int AGE_W = clog2(WAYS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    access_en,
    input  logic [AGE_W-1:0]        access_way,
    output logic [WAYS*AGE_W-1:0]   ages,
    output logic [AGE_W-1:0]        lru_way
);

    logic [AGE_W-1:0] age_r [WAYS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int w = 0; w < WAYS; w++) begin
                age_r[w] <= AGE_W'(w);
            end
        end else if (access_en) begin
            for (int w = 0; w < WAYS; w++) begin
                if (AGE_W'(w) == access_way) begin
                    age_r[w] <= '0;
                end else if (age_r[w] < age_r[access_way]) begin
                    age_r[w] <= age_r[w] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        ages    = '0;
        lru_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            ages[w*AGE_W +: AGE_W] = age_r[w];
            if (age_r[w] == AGE_W'(WAYS - 1)) begin
                lru_way = AGE_W'(w);
            end
        end
    end

endmodule

// File: rtl/assoc_cache_wb.sv
// N-way set-associative write-back/write-allocate cache, one word per line, with an FSM that
// performs the victim writeback and refill over a req/ack memory port.
module assoc_cache_wb
    import cache_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 8,
    parameter int WAYS   = 4,
    parameter int SETS   = 16,
    localparam int IDX_W = clog2(SETS),
    localparam int TAG_W = ADDR_W - IDX_W,
    localparam int AGE_W = clog2(WAYS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_hit,
    output logic [AGE_W-1:0]      resp_way,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic [15:0]           hit_count,
    output logic [15:0]           miss_count,
    output logic [2:0]            dbg_state,
    output logic [WAYS*AGE_W-1:0] dbg_ages
);

    // Handshake: a request is taken on a rising edge where req_valid && req_ready; req_ready is
    // high only in IDLE, so anything offered while busy is dropped. A memory transaction is
    // open while mem_req is high and completes on the edge where mem_ack is high; mem_ack
    // with mem_req low is ignored.

    typedef struct packed {
        logic              valid;
        logic              dirty;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } line_t;

    state_t            state;
    line_t             lines [SETS][WAYS];

    logic              lat_we;
    logic [TAG_W-1:0]  lat_tag;
    logic [IDX_W-1:0]  lat_idx;
    logic [DATA_W-1:0] lat_wdata;
    logic [AGE_W-1:0]  victim;

    logic              hit;
    logic [AGE_W-1:0]  hit_way;
    logic              inv_found;
    logic [AGE_W-1:0]  inv_way;
    logic [AGE_W-1:0]  victim_next;
    logic              fill_done;
    logic [DATA_W-1:0] fill_data;
    logic              lru_en;
    logic [AGE_W-1:0]  lru_way_sel;

    logic [WAYS*AGE_W-1:0] set_ages [SETS];
    logic [AGE_W-1:0]      set_lru  [SETS];

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && lines[lat_idx][w].valid && lines[lat_idx][w].tag == lat_tag) begin
                hit     = 1'b1;
                hit_way = AGE_W'(w);
            end
            if (!inv_found && !lines[lat_idx][w].valid) begin
                inv_found = 1'b1;
                inv_way   = AGE_W'(w);
            end
        end
    end

    assign victim_next = inv_found ? inv_way : set_lru[lat_idx];
    assign fill_done   = (state == ST_FILL) && mem_req && mem_ack;
    // A write miss installs the write data directly; the refilled word is overwritten anyway.
    assign fill_data   = lat_we ? lat_wdata : mem_rdata;
    assign lru_en      = ((state == ST_LOOKUP) && hit) || fill_done;
    assign lru_way_sel = (state == ST_LOOKUP) ? hit_way : victim;

    for (genvar s = 0; s < SETS; s++) begin : g_set
        cache_lru_set #(
            .WAYS (WAYS)
        ) u_lru (
            .clk        (clk),
            .rst        (rst),
            .access_en  (lru_en && (lat_idx == IDX_W'(s))),
            .access_way (lru_way_sel),
            .ages       (set_ages[s]),
            .lru_way    (set_lru[s])
        );
    end

    assign dbg_state = state;
    assign dbg_ages  = set_ages[lat_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_hit   <= 1'b0;
            resp_way   <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            hit_count  <= '0;
            miss_count <= '0;
            lat_we     <= 1'b0;
            lat_tag    <= '0;
            lat_idx    <= '0;
            lat_wdata  <= '0;
            victim     <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    lines[s][w] <= '0;
                end
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        lat_we    <= req_we;
                        lat_tag   <= req_addr[ADDR_W-1:IDX_W];
                        lat_idx   <= req_addr[IDX_W-1:0];
                        lat_wdata <= req_wdata;
                        req_ready <= 1'b0;
                        state     <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (hit) begin
                        if (lat_we) begin
                            lines[lat_idx][hit_way].data  <= lat_wdata;
                            lines[lat_idx][hit_way].dirty <= 1'b1;
                            resp_rdata                    <= lat_wdata;
                        end else begin
                            resp_rdata <= lines[lat_idx][hit_way].data;
                        end
                        resp_hit   <= 1'b1;
                        resp_way   <= hit_way;
                        resp_valid <= 1'b1;
                        if (hit_count != 16'hFFFF) begin
                            hit_count <= hit_count + 16'd1;
                        end
                        state <= ST_RESP;
                    end else begin
                        if (miss_count != 16'hFFFF) begin
                            miss_count <= miss_count + 16'd1;
                        end
                        victim <= victim_next;
                        if (lines[lat_idx][victim_next].valid && lines[lat_idx][victim_next].dirty) begin
                            state <= ST_WB;
                        end else begin
                            state <= ST_FILL;
                        end
                    end
                end
                // Each memory state spends its first cycle raising mem_req with stable fields.
                ST_WB: begin
                    if (!mem_req) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= {lines[lat_idx][victim].tag, lat_idx};
                        mem_wdata <= lines[lat_idx][victim].data;
                    end else if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= {lat_tag, lat_idx};
                    end else if (mem_ack) begin
                        mem_req                     <= 1'b0;
                        lines[lat_idx][victim].valid <= 1'b1;
                        lines[lat_idx][victim].dirty <= lat_we;
                        lines[lat_idx][victim].tag   <= lat_tag;
                        lines[lat_idx][victim].data  <= fill_data;
                        resp_rdata                  <= fill_data;
                        resp_hit                    <= 1'b0;
                        resp_way                    <= victim;
                        resp_valid                  <= 1'b1;
                        state                       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: begin
                    req_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_assoc_cache_wb.sv
// Bench for assoc_cache_wb: a recency-list cache model plus a memory model drive directed
// scenarios and randomized traffic; memory transactions are checked against an expected queue.
module tb_assoc_cache_wb;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 8;
    localparam int WAYS   = 4;
    localparam int SETS   = 16;
    localparam int AGE_W  = 2;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  req_valid = 1'b0;
    logic                  req_we = 1'b0;
    logic [ADDR_W-1:0]     req_addr = '0;
    logic [DATA_W-1:0]     req_wdata = '0;
    logic                  req_ready;
    logic                  resp_valid;
    logic [DATA_W-1:0]     resp_rdata;
    logic                  resp_hit;
    logic [AGE_W-1:0]      resp_way;
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic                  mem_ack = 1'b0;
    logic [DATA_W-1:0]     mem_rdata = '0;
    logic [15:0]           hit_count;
    logic [15:0]           miss_count;
    logic [2:0]            dbg_state;
    logic [WAYS*AGE_W-1:0] dbg_ages;

    always #5 clk = ~clk;

    assoc_cache_wb #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .WAYS   (WAYS),
        .SETS   (SETS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_hit   (resp_hit),
        .resp_way   (resp_way),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .hit_count  (hit_count),
        .miss_count (miss_count),
        .dbg_state  (dbg_state),
        .dbg_ages   (dbg_ages)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: per-set way contents plus a recency list (front = most recent).
    logic        m_valid [SETS][WAYS];
    logic        m_dirty [SETS][WAYS];
    logic [27:0] m_tag   [SETS][WAYS];
    logic [7:0]  m_data  [SETS][WAYS];
    int          m_order [SETS][$];
    logic [7:0]  mem_model [logic [31:0]];
    int          exp_hits;
    int          exp_misses;

    // Scoreboard of expected memory transactions: {we, addr, wdata (0 for refills)}.
    logic [40:0] exp_q[$];
    int          fixed_delay   = -1;
    bit          hold_ack      = 1'b0;
    int          wb_seen       = 0;
    int          resp_seen     = 0;
    int          resp_expected = 0;

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            m_order[s].delete();
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
                m_tag[s][w]   = '0;
                m_data[s][w]  = '0;
                m_order[s].push_back(w);
            end
        end
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    function automatic logic [WAYS*AGE_W-1:0] exp_ages_for(input int s);
        logic [WAYS*AGE_W-1:0] r;
        r = '0;
        for (int p = 0; p < m_order[s].size(); p++) begin
            r[m_order[s][p]*AGE_W +: AGE_W] = 2'(p);
        end
        return r;
    endfunction

    task automatic predict(input logic we, input logic [31:0] addr, input logic [7:0] wd,
                           output logic e_hit, output int e_way, output logic [7:0] e_rd);
        logic [3:0]  idx;
        logic [27:0] tag;
        logic [31:0] vaddr;
        idx   = addr[3:0];
        tag   = addr[31:4];
        e_hit = 1'b0;
        e_way = 0;
        for (int w = 0; w < WAYS; w++) begin
            if (!e_hit && m_valid[idx][w] && m_tag[idx][w] == tag) begin
                e_hit = 1'b1;
                e_way = w;
            end
        end
        if (e_hit) begin
            if (exp_hits < 65535) exp_hits++;
        end else begin
            if (exp_misses < 65535) exp_misses++;
            e_way = -1;
            for (int w = 0; w < WAYS; w++) begin
                if (e_way < 0 && !m_valid[idx][w]) e_way = w;
            end
            if (e_way < 0) e_way = m_order[idx][WAYS-1];
            if (m_valid[idx][e_way] && m_dirty[idx][e_way]) begin
                vaddr            = {m_tag[idx][e_way], idx};
                mem_model[vaddr] = m_data[idx][e_way];
                exp_q.push_back({1'b1, vaddr, m_data[idx][e_way]});
            end
            if (!mem_model.exists(addr)) mem_model[addr] = 8'($urandom);
            exp_q.push_back({1'b0, addr, 8'h00});
            m_valid[idx][e_way] = 1'b1;
            m_dirty[idx][e_way] = 1'b0;
            m_tag[idx][e_way]   = tag;
            m_data[idx][e_way]  = mem_model[addr];
        end
        if (we) begin
            m_data[idx][e_way]  = wd;
            m_dirty[idx][e_way] = 1'b1;
        end
        e_rd = m_data[idx][e_way];
        for (int p = 0; p < m_order[idx].size(); p++) begin
            if (m_order[idx][p] == e_way) begin
                m_order[idx].delete(p);
                break;
            end
        end
        m_order[idx].push_front(e_way);
    endtask

    // Memory responder: checks each transaction as it opens, acks after a delay.
    initial begin
        int          wait_cnt;
        bit          busy;
        logic [40:0] e;
        logic [40:0] got;
        busy     = 1'b0;
        wait_cnt = 0;
        forever begin
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = 8'($urandom);
            if (mem_req === 1'b1 && rst === 1'b0) begin
                if (!busy) begin
                    busy     = 1'b1;
                    wait_cnt = (fixed_delay >= 0) ? fixed_delay : $urandom_range(0, 3);
                    got      = {mem_we, mem_addr, (mem_we ? mem_wdata : 8'h00)};
                    if (mem_we) wb_seen++;
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL mem_txn unexpected: got %h, none expected", got);
                    end else begin
                        e = exp_q.pop_front();
                        if (got !== e) begin
                            miscompares++;
                            $display("FAIL mem_txn: got %h, expected %h", got, e);
                        end
                    end
                end
                if (!hold_ack) begin
                    if (wait_cnt == 0) begin
                        mem_ack   = 1'b1;
                        mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 8'h00;
                    end else begin
                        wait_cnt--;
                    end
                end
            end else begin
                busy = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (resp_valid === 1'b1) resp_seen++;
        end
    end

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [7:0] wd,
                          input bit spam, input string name);
        logic       e_hit;
        int         e_way;
        logic [7:0] e_rd;
        int         n;
        predict(we, addr, wd, e_hit, e_way, e_rd);
        @(negedge clk);
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        @(negedge clk);
        n = 1;
        while (resp_valid !== 1'b1 && n < 300) begin
            if (spam) begin
                req_valid = 1'($urandom_range(0, 1));
                req_we    = 1'($urandom_range(0, 1));
                req_addr  = $urandom;
                req_wdata = 8'($urandom);
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        req_valid = 1'b0;
        resp_expected++;
        vectors++;
        if (resp_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL %s timeout: no resp_valid after %0d cycles", name, n);
        end else begin
            if (resp_rdata !== e_rd) begin
                miscompares++;
                $display("FAIL %s rdata: got %h, expected %h", name, resp_rdata, e_rd);
            end
            vectors++;
            if (resp_hit !== e_hit) begin
                miscompares++;
                $display("FAIL %s hit: got %b, expected %b", name, resp_hit, e_hit);
            end
            vectors++;
            if (resp_way !== 2'(e_way)) begin
                miscompares++;
                $display("FAIL %s way: got %0d, expected %0d", name, resp_way, e_way);
            end
            vectors++;
            if (hit_count !== 16'(exp_hits) || miss_count !== 16'(exp_misses)) begin
                miscompares++;
                $display("FAIL %s counters: got %0d/%0d, expected %0d/%0d", name,
                         hit_count, miss_count, exp_hits, exp_misses);
            end
            vectors++;
            if (dbg_ages !== exp_ages_for(int'(addr[3:0]))) begin
                miscompares++;
                $display("FAIL %s ages: got %h, expected %h", name, dbg_ages,
                         exp_ages_for(int'(addr[3:0])));
            end
            if (e_hit) begin
                vectors++;
                if (n != 2) begin
                    miscompares++;
                    $display("FAIL %s hit_latency: got %0d cycles, expected 2", name, n);
                end
            end
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        model_reset();
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctl: ready=%b resp_valid=%b mem_req=%b, expected 1/0/0",
                     req_ready, resp_valid, mem_req);
        end
        vectors++;
        if (hit_count !== 16'd0 || miss_count !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_counters: got %0d/%0d, expected 0/0", hit_count, miss_count);
        end
        vectors++;
        if (resp_rdata !== 8'h00 || resp_way !== 2'd0 || mem_we !== 1'b0 || mem_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: rdata=%h way=%0d mem_we=%b mem_addr=%h, expected zeros",
                     resp_rdata, resp_way, mem_we, mem_addr);
        end
        vectors++;
        if (dbg_ages !== exp_ages_for(0)) begin
            miscompares++;
            $display("FAIL reset_ages: got %h, expected %h", dbg_ages, exp_ages_for(0));
        end
    endtask

    task automatic test_first_miss();
        mem_model[32'h13] = 8'hA5;
        fixed_delay = 2;
        do_req(1'b0, 32'h13, 8'h00, 1'b0, "first_miss");
        fixed_delay = -1;
        vectors++;
        if (resp_rdata !== 8'hA5 || resp_hit !== 1'b0 || miss_count !== 16'd1) begin
            miscompares++;
            $display("FAIL first_miss_plan: rdata=%h hit=%b misses=%0d, expected a5/0/1",
                     resp_rdata, resp_hit, miss_count);
        end
    endtask

    task automatic test_read_hit();
        do_req(1'b0, 32'h13, 8'h00, 1'b0, "read_hit");
    endtask

    task automatic test_write_alloc();
        do_req(1'b1, 32'h23, 8'h5C, 1'b0, "write_alloc");
        do_req(1'b0, 32'h23, 8'h00, 1'b0, "write_alloc_readback");
    endtask

    task automatic test_evict_clean();
        int wb_before;
        do_req(1'b0, 32'h33, 8'h00, 1'b0, "fill_tag3");
        do_req(1'b0, 32'h43, 8'h00, 1'b0, "fill_tag4");
        vectors++;
        if (dbg_ages[1:0] !== 2'd3) begin
            miscompares++;
            $display("FAIL evict_clean_age: way0 age %0d, expected 3", dbg_ages[1:0]);
        end
        wb_before = wb_seen;
        do_req(1'b0, 32'h53, 8'h00, 1'b0, "evict_clean");
        vectors++;
        if (wb_seen != wb_before) begin
            miscompares++;
            $display("FAIL evict_clean_nowb: %0d writebacks, expected 0", wb_seen - wb_before);
        end
    endtask

    task automatic test_evict_dirty();
        int wb_before;
        do_req(1'b1, 32'h23, 8'h77, 1'b0, "dirty_write");
        do_req(1'b0, 32'h33, 8'h00, 1'b0, "touch_tag3");
        do_req(1'b0, 32'h43, 8'h00, 1'b0, "touch_tag4");
        do_req(1'b0, 32'h53, 8'h00, 1'b0, "touch_tag5");
        wb_before = wb_seen;
        do_req(1'b0, 32'h63, 8'h00, 1'b0, "evict_dirty");
        vectors++;
        if (wb_seen != wb_before + 1) begin
            miscompares++;
            $display("FAIL evict_dirty_wb: %0d writebacks, expected 1", wb_seen - wb_before);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        for (int i = 0; i < 300; i++) begin
            a = {24'(0), 4'($urandom_range(0, 5)), 4'($urandom_range(0, 3))};
            do_req(1'($urandom_range(0, 1)), a, 8'($urandom), 1'($urandom_range(0, 1)), "random");
        end
    endtask

    task automatic test_reset_mid();
        logic       e_hit;
        int         e_way;
        logic [7:0] e_rd;
        int         n;
        int         seen_before;
        predict(1'b0, 32'h7A, 8'h00, e_hit, e_way, e_rd);
        hold_ack = 1'b1;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h7A;
        @(negedge clk);
        n = 0;
        while (!(mem_req === 1'b1 && mem_we === 1'b0) && n < 50) begin
            req_valid = 1'($urandom_range(0, 1));
            req_addr  = $urandom;
            @(negedge clk);
            n++;
        end
        vectors++;
        if (mem_req !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_fill: no refill request after %0d cycles", n);
        end
        repeat (3) begin
            req_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        req_valid   = 1'b0;
        seen_before = resp_seen;
        rst = 1'b1;
        #1;
        vectors++;
        if (mem_req !== 1'b0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_immediate: mem_req=%b ready=%b, expected 0/1", mem_req, req_ready);
        end
        vectors++;
        if (hit_count !== 16'd0 || miss_count !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_mid_counters: got %0d/%0d, expected 0/0", hit_count, miss_count);
        end
        @(negedge clk);
        rst      = 1'b0;
        hold_ack = 1'b0;
        exp_q.delete();
        model_reset();
        vectors++;
        if (resp_seen != seen_before) begin
            miscompares++;
            $display("FAIL reset_mid_noresp: %0d responses, expected 0", resp_seen - seen_before);
        end
        do_req(1'b0, 32'h13, 8'h00, 1'b0, "reread_after_reset");
        vectors++;
        if (resp_hit !== 1'b0) begin
            miscompares++;
            $display("FAIL reread_miss: hit=%b, expected 0", resp_hit);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_miss();
        test_read_hit();
        test_write_alloc();
        test_evict_clean();
        test_evict_dirty();
        test_back_to_back();
        test_reset_mid();
        repeat (3) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL mem_txn_leftover: %0d expected transactions never seen", exp_q.size());
        end
        vectors++;
        if (resp_seen != resp_expected) begin
            miscompares++;
            $display("FAIL resp_count: got %0d responses, expected %0d", resp_seen, resp_expected);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/assoc_cache_wb.md
Name: assoc_cache_wb

Overview:
- Parametrised N-way set-associative cache with true-LRU age counters, write-back/write-allocate policy and a request/acknowledge backing-memory port.
- Next generation of the team's 4-way cache_memory:
  - Ways, sets, address width and data width are generic.
  - Tracks dirty lines.
  - Performs the victim writeback and refill itself through an FSM.
- Sits between the CPU-side request port and the memory model or arbiter.

Parameters:
- ADDR_W, 32: request address width
- DATA_W, 8: data word width (one word per line)
- WAYS, 4: associativity, power of 2, at least 2
- SETS, 16: number of sets, power of 2, at least 2
- Derived: IDX_W = log2(SETS); TAG_W = ADDR_W - IDX_W; AGE_W = log2(WAYS)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  CPU request present
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  byte/word address
- req_wdata  in  DATA_W  write data
- req_ready  out  1  block can accept a request
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  DATA_W  read data (write: the newly written value)
- resp_hit  out  1  1 = request hit
- resp_way  out  AGE_W  way serviced
- mem_req  out  1  memory transaction request
- mem_we  out  1  1 = writeback, 0 = refill read
- mem_addr  out  ADDR_W  {tag, index}
- mem_wdata  out  DATA_W  victim data
- mem_ack  in  1  memory done; mem_rdata valid this cycle for reads
- mem_rdata  in  DATA_W  refill data
- hit_count  out  16  saturating hit counter
- miss_count  out  16  saturating miss counter

Behaviour:
- Reset (asynchronous, effective immediately):
  - FSM goes to IDLE.
  - All valid and dirty bits clear.
  - Age of way w in every set = w.
  - Counters = 0.
  - Outputs 0, except req_ready = 1.
- Address split: index = req_addr[IDX_W-1:0]; tag = req_addr[ADDR_W-1:IDX_W].
- States: IDLE, LOOKUP, WB, FILL, RESP.
- IDLE:
  - req_ready = 1.
  - req_valid = 1 at a clock edge latches we/addr/wdata and moves to LOOKUP.
- LOOKUP:
  - req_ready = 0.
  - Compare the latched tag against all valid ways of the set.
  - Hit: perform the access, update LRU, increment hit_count, go to RESP.
  - Miss: increment miss_count; pick the victim:
    - the lowest-index invalid way, else
    - the way with age = WAYS-1.
  - Victim valid and dirty: go to WB, else go to FILL.
- WB:
  - mem_req = 1, mem_we = 1, mem_addr = {victim tag, index}, mem_wdata = victim data.
  - Outputs held stable until mem_ack, then go to FILL.
  - mem_req is 0 in the cycle after the ack.
- FILL:
  - mem_req = 1, mem_we = 0, mem_addr = {latched tag, index}.
  - On mem_ack: install mem_rdata in the victim way (valid = 1, tag written), then perform the access as on a hit, then go to RESP.
- Access rules:
  - Read: returns the line data, dirty bit unchanged.
  - Write: stores wdata and sets dirty = 1.
- LRU update on every access to way k with old age a:
  - age[k] becomes 0.
  - Any way with age < a increments.
  - All other ways unchanged.
  - Ages in each set always remain a permutation of 0..WAYS-1.
- RESP:
  - resp_valid = 1 for exactly one cycle with rdata/hit/way.
  - resp_hit = 0 for any request that passed through FILL.
  - Return to IDLE; the next request can be accepted in the following cycle.
- Latency:
  - Hit: accepted at edge N, resp_valid high during cycle N+2.
  - Miss: adds the mem_ack wait of each memory transaction plus one cycle per transaction.
- Ignored inputs:
  - req_valid while req_ready = 0 is ignored; no queueing.
  - mem_ack while mem_req = 0 is ignored.
  - mem_ack may arrive in the first cycle of mem_req.
- Counters saturate at 16'hFFFF.
- Reset mid-operation: the transaction is abandoned; no partial line is installed, and mem_req falls immediately.

Decomposition:
- Package cache_pkg holds:
  - the state enum;
  - the derived-width functions (clog2 wrapper);
  - the line record type {valid, dirty, tag, data}.
- One sub-module, cache_lru_set: age vector for one set, with inputs access_en and access_way, and outputs ages and lru_way.
  - Instantiate SETS copies, or one copy with per-set storage muxed by index.

Test Plan:
- After reset, read 0x00000013 with mem_ack after 2 cycles and mem_rdata = 0xA5:
  - mem_req with mem_we = 0, mem_addr = 0x13.
  - Response rdata = 0xA5, hit = 0, way = 0; miss_count = 1.
- Read 0x00000013 again:
  - resp_valid 2 cycles after acceptance, hit = 1, way = 0, rdata = 0xA5, no mem_req; hit_count = 1.
- Write 0x00000023 with data 0x5C (set 3, new tag):
  - Miss, filled into way 1; a following read of 0x23 hits with rdata = 0x5C.
- Fill set 3 with tags 1, 2, 3, 4, then access tag 5 (address 0x53) with tag 1 the least recently used:
  - Victim is way 0, its age = 3 beforehand.
  - Way 0 is clean, so FILL only, no WB.
- Repeat with the victim made dirty via a write of 0x77:
  - WB first: mem_we = 1, mem_addr = old {tag, index}, mem_wdata = 0x77.
  - Then FILL.
- Assert rst during FILL while mem_ack is withheld:
  - mem_req = 0 immediately, counters = 0.
  - A re-read of a previously cached address misses.
  - req_valid pulses raised during the busy states produce no extra responses.
